// File: rtl/game_pkg.sv
// Shared types and constants for the game drawing path.
// State encoding, screen geometry and 3-bit RGB colours.
package game_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PREP,
    BG,
    PLAYER,
    WAIT,
    ERASE,
    UPDATE,
    GAMEOVER,
    HOLD
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] rgb_t;

  localparam rgb_t COL_BLACK = 3'b000;
  localparam rgb_t COL_BLUE  = 3'b001;
  localparam rgb_t COL_GREEN = 3'b010;
  localparam rgb_t COL_RED   = 3'b100;
  localparam rgb_t COL_WHITE = 3'b111;

endpackage

// File: rtl/game_draw_controller_if.sv
// Controller <-> drawers/game-logic bundle.
// GAME_PAUSE_EN adds the pause input.
interface game_draw_controller_if;

  logic start;
  logic collision;
  logic doneDrawBg;
  logic doneDrawPlayer;
  logic doneErase;
  logic doneDrawGameover;
`ifdef GAME_PAUSE_EN
  logic pause;
`endif
  logic drawRst_n;
  logic DrawBgState;
  logic DrawPlayerState;
  logic EraseState;
  logic UpdateState;
  logic DrawGameoverState;
  logic plot;
  logic frame_tick;

  modport master (
`ifdef GAME_PAUSE_EN
    input  pause,
`endif
    input  start,
    input  collision,
    input  doneDrawBg,
    input  doneDrawPlayer,
    input  doneErase,
    input  doneDrawGameover,
    output drawRst_n,
    output DrawBgState,
    output DrawPlayerState,
    output EraseState,
    output UpdateState,
    output DrawGameoverState,
    output plot,
    output frame_tick
  );

  modport slave (
`ifdef GAME_PAUSE_EN
    output pause,
`endif
    output start,
    output collision,
    output doneDrawBg,
    output doneDrawPlayer,
    output doneErase,
    output doneDrawGameover,
    input  drawRst_n,
    input  DrawBgState,
    input  DrawPlayerState,
    input  EraseState,
    input  UpdateState,
    input  DrawGameoverState,
    input  plot,
    input  frame_tick
  );

endinterface

// File: rtl/frame_ticker.sv
// Free-running divider: one-cycle tick every CLK_HZ/FRAME_HZ clocks.
// The tick is a decode of the counter's terminal count.
module frame_ticker #(
  parameter int CLK_HZ   = 50000000,
  parameter int FRAME_HZ = 60
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_HZ / FRAME_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/game_draw_controller.sv
// Sequencing FSM for the VGA drawing path (bg/player/erase/gameover).
// Optional GAME_PAUSE_EN freezes the WAIT move counter while paused.
module game_draw_controller #(
  parameter int CLK_HZ          = 50000000,
  parameter int FRAME_HZ        = 60,
  parameter int FRAMES_PER_MOVE = 4
) (
  input logic                   clk,
  input logic                   reset,
  game_draw_controller_if.master bus
);

  import game_pkg::*;

  localparam int MC = $clog2(FRAMES_PER_MOVE + 1);
  localparam int MW = (MC < 3) ? 3 : MC;
  localparam logic [MW-1:0] MOVE_LAST =
    MW'(FRAMES_PER_MOVE - 1);

  state_t        state, state_n;
  state_t        target, target_n;
  logic [MW-1:0] move, move_n;
  logic          start_q;
  logic          rise;
  logic          tick;
  logic          hold;
  logic          drawing;

  frame_ticker #(
    .CLK_HZ   (CLK_HZ),
    .FRAME_HZ (FRAME_HZ)
  ) u_ticker (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign bus.frame_tick = tick;
  assign rise = bus.start & ~start_q;

`ifdef GAME_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      target  <= IDLE;
      move    <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      target  <= target_n;
      move    <= move_n;
      start_q <= bus.start;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    move_n   = move;
    unique case (state)
      IDLE, HOLD: begin
        if (rise) begin
          target_n = BG;
          state_n  = PREP;
        end
      end
      PREP: state_n = target;
      BG: begin
        if (bus.doneDrawBg) begin
          target_n = PLAYER;
          state_n  = PREP;
        end
      end
      PLAYER: begin
        if (bus.doneDrawPlayer) begin
          state_n = WAIT;
          move_n  = '0;
        end
      end
      WAIT: begin
        if (tick && !hold) begin
          if (move == MOVE_LAST) begin
            target_n = ERASE;
            state_n  = PREP;
          end else begin
            move_n = move + MW'(1);
          end
        end
      end
      ERASE: begin
        if (bus.doneErase) state_n = UPDATE;
      end
      UPDATE: begin
        target_n = bus.collision ? GAMEOVER : PLAYER;
        state_n  = PREP;
      end
      GAMEOVER: begin
        if (bus.doneDrawGameover) state_n = HOLD;
      end
      default: state_n = IDLE;
    endcase
  end

  // A drawer emits a pixel the cycle after it is enabled and not done.
  assign drawing =
    (bus.DrawBgState       & ~bus.doneDrawBg)     |
    (bus.DrawPlayerState   & ~bus.doneDrawPlayer) |
    (bus.EraseState        & ~bus.doneErase)      |
    (bus.DrawGameoverState & ~bus.doneDrawGameover);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.drawRst_n         <= 1'b1;
      bus.DrawBgState       <= 1'b0;
      bus.DrawPlayerState   <= 1'b0;
      bus.EraseState        <= 1'b0;
      bus.UpdateState       <= 1'b0;
      bus.DrawGameoverState <= 1'b0;
      bus.plot              <= 1'b0;
    end else begin
      bus.drawRst_n         <= (state_n != PREP);
      bus.DrawBgState       <= (state_n == BG);
      bus.DrawPlayerState   <= (state_n == PLAYER);
      bus.EraseState        <= (state_n == ERASE);
      bus.UpdateState       <= (state_n == UPDATE);
      bus.DrawGameoverState <= (state_n == GAMEOVER);
      bus.plot              <= drawing;
    end
  end

endmodule

// File: doc/game_draw_controller.md
Name: game_draw_controller

Overview:
- Top-level sequencing FSM for the game's VGA drawing path, directly upstream of the full-screen and sprite drawers.
- Issues one-hot state enables (background, player, erase, update, game-over) and a per-stage drawer clear pulse.
- Waits on each drawer's sticky done flag and paces movement with an internal frame-tick counter.
- Generates the VGA adapter plot (write-enable) aligned with the drawers' registered pixel outputs.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- FRAME_HZ, 60, frame-tick rate in Hz; tick period = CLK_HZ/FRAME_HZ cycles.
- FRAMES_PER_MOVE, 4, frame ticks spent in WAIT before each erase/update step.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  level from debounced key; rising edge detected internally.
- collision  in  1  from game logic; sampled only in UPDATE.
- doneDrawBg  in  1  sticky done from background drawer.
- doneDrawPlayer  in  1  sticky done from player drawer.
- doneErase  in  1  sticky done from erase drawer.
- doneDrawGameover  in  1  sticky done from game-over drawer.
- drawRst_n  out  1  active-low drawer clear; low for exactly one cycle before every draw stage.
- DrawBgState  out  1  background drawer enable.
- DrawPlayerState  out  1  player drawer enable.
- EraseState  out  1  erase drawer enable.
- UpdateState  out  1  one-cycle game-logic update strobe.
- DrawGameoverState  out  1  game-over drawer enable.
- plot  out  1  VGA write-enable.
- frame_tick  out  1  one-cycle pulse every CLK_HZ/FRAME_HZ cycles.

Behaviour:
- Reset values while reset=0: state=IDLE, all enables 0, plot 0, frame_tick 0, drawRst_n 1, counters 0, start-edge register 0.
- States: IDLE, PREP, BG, PLAYER, WAIT, ERASE, UPDATE, GAMEOVER, HOLD.
- PREP is a one-cycle state that drives drawRst_n=0 and moves to the stage held in a registered target.
- IDLE: on a start rising edge, target=BG, go to PREP.
- BG: DrawBgState=1; when doneDrawBg=1, target=PLAYER, go to PREP.
- PLAYER: DrawPlayerState=1; when doneDrawPlayer=1, go to WAIT and clear the move counter.
- WAIT: count frame_tick pulses. On the FRAMES_PER_MOVE-th tick, target=ERASE, go to PREP.
- ERASE: EraseState=1; when doneErase=1, go to UPDATE.
- UPDATE: exactly one cycle with UpdateState=1.
  - collision=1: target=GAMEOVER.
  - collision=0: target=PLAYER.
  - Either way, go to PREP.
- GAMEOVER: DrawGameoverState=1; when doneDrawGameover=1, go to HOLD.
- HOLD: all enables 0; on a start rising edge, target=BG, go to PREP (restart).
- Enable outputs are registered and one-hot (at most one high). They are all low in IDLE, PREP, WAIT and HOLD.
- Done inputs are ignored outside their matching state. A done already high on entry cannot occur, because PREP clears it.
- plot is registered: plot(t+1) = (BG|PLAYER|ERASE|GAMEOVER enable at t) AND NOT matching done at t. This matches the drawers' one-cycle registered pixel latency.
- Frame counter:
  - Width is $clog2(CLK_HZ/FRAME_HZ).
  - Free-running from reset.
  - Wraps to 0 at CLK_HZ/FRAME_HZ-1, asserting frame_tick in that cycle.
- Move counter:
  - 3 bits minimum; sized with $clog2(FRAMES_PER_MOVE+1).
  - Cleared on WAIT entry.
- A start edge outside IDLE/HOLD is discarded.
- Asserting reset mid-stage drops all enables immediately and returns to IDLE.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined: adds input pause (1 bit). While pause=1 in WAIT, the move counter holds and no transition occurs. frame_tick keeps running. Pause has no effect in other states.
- Undefined: no pause port; WAIT always advances on ticks.

Decomposition:
- Shared package game_pkg holds:
  - The state enum (IDLE..HOLD).
  - Screen constants SCREEN_W=160, SCREEN_H=120.
  - Colour constants, 3-bit RGB.
- One natural sub-module: frame_ticker (parameterised divider producing frame_tick). It is instantiated inside the controller and reusable elsewhere.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, start=0 for 100 cycles -> all enables 0, drawRst_n=1, plot=0.
- Start sequence: pulse start high; doneDrawBg rises 19200 cycles later -> drawRst_n low one cycle, then DrawBgState=1; plot high exactly while BG is active and done is low; then PREP, then DrawPlayerState=1.
- Movement loop (CLK_HZ=600, FRAME_HZ=60, FRAMES_PER_MOVE=4): after doneDrawPlayer, WAIT lasts 4 ticks (≤40 cycles) -> EraseState; after doneErase, UpdateState high exactly 1 cycle; collision=0 -> back to PLAYER.
- Game over: collision=1 during UPDATE -> PREP, then DrawGameoverState; after doneDrawGameover -> HOLD; next start edge -> BG again.
- Reset mid-draw: assert reset while DrawBgState=1 -> same-cycle asynchronous clear of all enables; state IDLE after release.
- GAME_PAUSE_EN: pause=1 during WAIT for 10 ticks -> no ERASE; release -> ERASE after the remaining ticks.
